// File: rtl/sramlike_axi_bridge_pkg.sv
// sramlike_axi_bridge_pkg: size codes, AXI constants, write FSM states and lane helpers for the bridge
package sramlike_axi_bridge_pkg;

    localparam logic [1:0] SZ_BYTE    = 2'd0;
    localparam logic [1:0] SZ_HALF    = 2'd1;
    localparam logic [1:0] SZ_WORD    = 2'd2;
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [7:0] LEN_SINGLE = 8'd0;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_SEND = 2'd1,
        W_RESP = 2'd2
    } wstate_t;

    // the unused size code 3 behaves as a word access
    function automatic logic [1:0] norm_size(input logic [1:0] sz);
        return (sz == 2'd3) ? SZ_WORD : sz;
    endfunction

    function automatic logic [3:0] strb_of(input logic [1:0] sz, input logic [1:0] a);
        return (sz == SZ_BYTE) ? 4'b0001 << a : (sz == SZ_HALF) ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    endfunction

endpackage

// File: rtl/sramlike_axi_bridge_arbiter.sv
// bridge_arbiter: one-hot grant from an eligibility vector; fixed highest-index priority, or round-robin when BRIDGE_RR_ARB_EN is defined
module bridge_arbiter #(
    parameter int NPORT = 2
) (
`ifdef BRIDGE_RR_ARB_EN
    input  logic             clk,
    input  logic             resetn,
`endif
    input  logic [NPORT-1:0] elig,
    output logic [NPORT-1:0] grant
);

`ifdef BRIDGE_RR_ARB_EN
    logic [3:0] ptr;
    logic [3:0] nxt;
    int         best;
    int         d;

    // pick the eligible port closest to the pointer, counting upward with wrap
    always_comb begin
        grant = '0;
        nxt   = ptr;
        best  = NPORT;
        d     = 0;
        for (int p = 0; p < NPORT; p++) begin
            d = (p >= int'(ptr)) ? p - int'(ptr) : p + NPORT - int'(ptr);
            if (elig[p] && d < best) begin
                best     = d;
                grant    = '0;
                grant[p] = 1'b1;
                nxt      = (p == NPORT - 1) ? 4'd0 : 4'(p + 1);
            end
        end
    end

    // pointer moves just past the port that was served
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            ptr <= '0;
        else if (|grant)
            ptr <= nxt;
    end
`else
    // later (higher) eligible ports override earlier ones
    always_comb begin
        grant = '0;
        for (int p = 0; p < NPORT; p++) begin
            if (elig[p]) begin
                grant    = '0;
                grant[p] = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/sramlike_axi_bridge.sv
// sramlike_axi_bridge: NPORT SRAM-like masters onto one AXI3 master with per-port ID routing and RAW blocking; BRIDGE_RR_ARB_EN selects round-robin arbitration
module sramlike_axi_bridge
    import sramlike_axi_bridge_pkg::*;
#(
    parameter int NPORT = 2,
    parameter int ID_W  = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [NPORT-1:0]      req,
    input  logic [NPORT-1:0]      wr,
    input  logic [2*NPORT-1:0]    size,
    input  logic [32*NPORT-1:0]   addr,
    input  logic [32*NPORT-1:0]   wdata,
    output logic [NPORT-1:0]      addr_ok,
    output logic [NPORT-1:0]      data_ok,
    output logic [31:0]           rdata,
    output logic [ID_W-1:0]       arid,
    output logic [31:0]           araddr,
    output logic [7:0]            arlen,
    output logic [2:0]            arsize,
    output logic [1:0]            arburst,
    output logic [1:0]            arlock,
    output logic [3:0]            arcache,
    output logic [2:0]            arprot,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [ID_W-1:0]       rid,
    input  logic [31:0]           r_data,
    input  logic [1:0]            rresp,
    input  logic                  rlast,
    input  logic                  rvalid,
    output logic                  rready,
    output logic [ID_W-1:0]       awid,
    output logic [31:0]           awaddr,
    output logic [7:0]            awlen,
    output logic [2:0]            awsize,
    output logic [1:0]            awburst,
    output logic [1:0]            awlock,
    output logic [3:0]            awcache,
    output logic [2:0]            awprot,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [ID_W-1:0]       wid,
    output logic [31:0]           w_data,
    output logic [3:0]            wstrb,
    output logic                  wlast,
    output logic                  wvalid,
    input  logic                  wready,
    input  logic [ID_W-1:0]       bid,
    input  logic [1:0]            bresp,
    input  logic                  bvalid,
    output logic                  bready
);

    logic [NPORT-1:0] pend;
    logic [NPORT-1:0] elig;
    logic [NPORT-1:0] grant;
    wstate_t          wstate;
    wstate_t          wstate_nxt;
    logic             aw_done;
    logic             w_done;
    logic [31:0]      g_addr;
    logic [31:0]      g_wdata;
    logic [1:0]       g_size;
    logic [ID_W-1:0]  g_id;
    logic             g_wr;
    logic             rd_grant;
    logic             wr_grant;
    logic             aw_hs;
    logic             w_hs;
    logic             send_done;
    logic             unused;

    assign arlen   = LEN_SINGLE;
    assign awlen   = LEN_SINGLE;
    assign arburst = BURST_INCR;
    assign awburst = BURST_INCR;
    assign arlock  = '0;
    assign awlock  = '0;
    assign arcache = '0;
    assign awcache = '0;
    assign arprot  = '0;
    assign awprot  = '0;
    assign rready  = 1'b1;
    assign wlast   = 1'b1;
    assign wid     = awid;
    assign unused  = ^{rresp, bresp, rlast};

    assign addr_ok   = grant;
    assign rd_grant  = |grant && !g_wr;
    assign wr_grant  = |grant && g_wr;
    assign aw_hs     = awvalid && awready;
    assign w_hs      = wvalid && wready;
    assign send_done = (aw_done || aw_hs) && (w_done || w_hs);
    assign rdata     = rvalid ? r_data : '0;

    // a port may go when idle and its channel is free; reads also wait out a pending write to the same word
    always_comb begin
        elig = '0;
        for (int p = 0; p < NPORT; p++) begin
            elig[p] = req[p] && !pend[p] && (wr[p] ? (wstate == W_IDLE)
                      : (!arvalid && !(wstate != W_IDLE && addr[p*32+2 +: 30] == awaddr[31:2])));
        end
    end

    bridge_arbiter #(.NPORT(NPORT)) u_arb (
`ifdef BRIDGE_RR_ARB_EN
        .clk    (clk),
        .resetn (resetn),
`endif
        .elig   (elig),
        .grant  (grant)
    );

    // select the request fields of the granted port
    always_comb begin
        g_addr  = '0;
        g_wdata = '0;
        g_size  = SZ_BYTE;
        g_id    = '0;
        g_wr    = 1'b0;
        for (int p = 0; p < NPORT; p++) begin
            if (grant[p]) begin
                g_addr  = addr[p*32 +: 32];
                g_wdata = wdata[p*32 +: 32];
                g_size  = norm_size(size[p*2 +: 2]);
                g_id    = ID_W'(p);
                g_wr    = wr[p];
            end
        end
    end

    // completions are routed back by AXI ID; an R and a B for different ports may coincide
    always_comb begin
        data_ok = '0;
        for (int p = 0; p < NPORT; p++) begin
            data_ok[p] = (rvalid && rid == ID_W'(p)) || (bvalid && bready && bid == ID_W'(p));
        end
    end

    // one outstanding transaction per port, freed by its own completion
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            pend <= '0;
        else
            pend <= (pend & ~data_ok) | grant;
    end

    // read address slot, loaded on a read grant and emptied by the handshake
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            arvalid <= 1'b0;
            araddr  <= '0;
            arsize  <= '0;
            arid    <= '0;
        end else if (rd_grant) begin
            arvalid <= 1'b1;
            araddr  <= g_addr;
            arsize  <= {1'b0, g_size};
            arid    <= g_id;
        end else if (arready) begin
            arvalid <= 1'b0;
        end
    end

    // write address/data latched on a write grant; awaddr also serves the RAW compare
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            awaddr <= '0;
            awsize <= '0;
            awid   <= '0;
            w_data <= '0;
            wstrb  <= '0;
        end else if (wr_grant) begin
            awaddr <= g_addr;
            awsize <= {1'b0, g_size};
            awid   <= g_id;
            w_data <= g_wdata;
            wstrb  <= strb_of(g_size, g_addr[1:0]);
        end
    end

    // AW and W complete independently; remember each handshake until both are done
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else if (wr_grant) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            aw_done <= aw_done || aw_hs;
            w_done  <= w_done || w_hs;
        end
    end

    // write FSM state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            wstate <= W_IDLE;
        else
            wstate <= wstate_nxt;
    end

    // write FSM transitions
    always_comb begin
        wstate_nxt = (wstate == W_IDLE) ? (wr_grant ? W_SEND : W_IDLE)
                   : (wstate == W_SEND) ? (send_done ? W_RESP : W_SEND)
                   : (wstate == W_RESP) ? (bvalid ? W_IDLE : W_RESP)
                   : W_IDLE;
    end

    // write FSM outputs
    always_comb begin
        awvalid = (wstate == W_SEND) && !aw_done;
        wvalid  = (wstate == W_SEND) && !w_done;
        bready  = (wstate == W_RESP);
    end

endmodule

// File: doc/sramlike_axi_bridge.md
Name: sramlike_axi_bridge

Overview:
- Parametrised successor to the fixed two-port (inst/data) SRAM-like-to-AXI3 bridge between the pipeline and the AXI ports of the CPU top.
- Arbitrates NPORT SRAM-like masters onto one AXI master interface.
- Each port may have one outstanding transaction. Reads from different ports may be outstanding concurrently and may return out of order; they are routed back by ID.
- Adds read-after-write hazard blocking, which the fixed bridge does not have.

Parameters:
- NPORT, 2, number of SRAM-like master ports (1..15); port index equals AXI ID.
- ID_W, 4, AXI ID width; 2**ID_W must be at least NPORT.

Ports:
- clk  in  1  clock; all state on rising edge
- resetn  in  1  asynchronous active-low reset
- req  in  NPORT  per-port request valid
- wr  in  NPORT  per-port 1=write, 0=read
- size  in  2*NPORT  per-port size: 0=byte, 1=half, 2=word; 3 is illegal
- addr  in  32*NPORT  per-port byte address
- wdata  in  32*NPORT  per-port write data, in lane position
- addr_ok  out  NPORT  request accepted this cycle (one-hot or zero)
- data_ok  out  NPORT  read data valid or write complete this cycle
- rdata  out  32  shared read data, qualified by data_ok
- AXI ar*, r*, aw*, w*, b* channels: widths as in the CPU top; arid/rid/awid/wid/bid are ID_W bits.

Behaviour:
- Reset values: all addr_ok/data_ok=0, arvalid=awvalid=wvalid=0, bready=0, rdata=0, pending flags cleared, write FSM in W_IDLE.
- Constant AXI fields: arlen/awlen=0; arburst/awburst=01; arlock/awlock=0; arcache/awcache=0; arprot/awprot=0; wlast=1; rready=1.
- arsize/awsize = {1'b0, size}.
- wstrb from size and addr[1:0]:
  - byte: 0001 shifted by addr[1:0]
  - half: 0011 if addr[1]=0, else 1100
  - word: 1111
- Eligibility: port p is eligible when all of:
  - req[p]=1 and pend[p]=0
  - read: AR slot free (arvalid=0), and no RAW hazard
  - write: write FSM in W_IDLE
- RAW hazard: read addr[31:2] equals the latched write addr[31:2] while the write FSM is not W_IDLE.
- Arbitration: at most one port is granted per cycle; fixed priority, highest index wins.
- Grant: addr_ok[p] is asserted combinationally in the same cycle as req[p]. Latch addr, size, wdata and p; set pend[p].
- Read path: granted read loads the AR register and sets arvalid next cycle. arvalid is held until arready, then cleared. The next AR may be loaded in the cycle after the handshake.
- R channel: on rvalid with rid=q, data_ok[q]=1 and rdata=r data in the same cycle (combinational pass-through); pend[q] cleared next edge.
- Write FSM:
  - W_IDLE -> W_SEND on write grant; awvalid and wvalid are asserted together.
  - Each of awvalid/wvalid drops independently on its own handshake, tracked by aw_done/w_done flags.
  - When both are done -> W_RESP with bready=1.
  - On bvalid with bid=q: data_ok[q]=1, pend[q] cleared, return to W_IDLE.
- Latency: read data_ok is no earlier than 2 cycles after addr_ok (grant edge, then AR handshake, then R); write data_ok is no earlier than 2 cycles after addr_ok.
- Simultaneous events:
  - R return and new grant on the same port in one cycle: the grant is refused, since pend is still set that cycle.
  - R return and B completion in one cycle on different ports: both data_ok bits assert.
  - rresp and bresp are ignored.
- Illegal size=3 is treated as word.
- Reset mid-operation clears all state immediately; in-flight AXI transactions are abandoned, since the slave shares resetn.

Optional Feature:
- BRIDGE_RR_ARB_EN defined: round-robin arbitration. The pointer advances to (granted index + 1) mod NPORT after each grant; the search starts at the pointer; the pointer resets to 0.
- Undefined: fixed priority, highest index wins.

Decomposition:
- Shared package holds:
  - size encodings (SZ_BYTE/SZ_HALF/SZ_WORD)
  - AXI constants (BURST_INCR, LEN_SINGLE)
  - write FSM state encoding W_IDLE/W_SEND/W_RESP
- Sub-module bridge_arbiter: NPORT eligibility vector in, one-hot grant out; it contains the optional round-robin pointer.

Test Plan:
- Read from port 0 only: addr=0xBFC00000, word; arready=1, R returns rid=0, data 0x3C1D0001 two cycles later -> addr_ok[0] in cycle 0, arvalid cycle 1, data_ok[0]=1 with rdata=0x3C1D0001, arsize=2.
- Simultaneous read requests on ports 0 and 1, fixed priority -> port 1 granted first; port 0 granted the cycle after the AR handshake. R returns rid=1 data 0x11, then rid=0 data 0x22 -> data_ok[1] then data_ok[0] with matching data.
- Port 1 byte write, addr=0x80000003, wdata=0xAB000000; awready delayed 3 cycles, wready immediate -> wstrb=1000, awsize=0, bready only in W_RESP, data_ok[1] on bvalid with bid=1.
- RAW: port 1 writes 0x80001000 while port 0 reads 0x80001002 -> port 0 addr_ok held at 0 until the cycle after bvalid, then granted.
- Round-robin (BRIDGE_RR_ARB_EN): ports 0 and 1 requesting continuously -> grants alternate 0,1,0,1; with the macro undefined, port 1 wins every contested cycle.
- Assert resetn=0 while arvalid=1 and in W_SEND -> arvalid/awvalid/wvalid drop asynchronously; after release, the first request is granted normally.
